mem_access_stage: RTL and testbench

- Pipeline stage directly downstream of the ALU. Consumes the EX-stage result (ALU result and zero flag, plus forwarded control and store data).
- Resolves branches, performs data-memory loads and stores over a req/ack handshake, and presents write-back data to the register file.
- Stalls the EX stage, through ex_ready, while a memory transfer is outstanding.

---
 rtl/mem_access_stage.sv | 145 ++++++++++++++
 tb/tb_mem_access_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage resolving branches and doing req/ack loads/stores; define MEM_ALIGN_CHECK_EN to fault misaligned accesses
module mem_access_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_zero,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic [RA_W-1:0]   ex_write_reg,
  input  logic [DATA_W-1:0] ex_branch_target,
  input  logic              ex_branch,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_branch_target,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [RA_W-1:0]   wb_write_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              align_fault
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
  logic pc_src_q, pc_src_d, wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
  logic [DATA_W-1:0] pc_target_q, pc_target_d, wb_data_q, wb_data_d, alu_q, alu_d;
  logic [RA_W-1:0] wb_write_reg_q, wb_write_reg_d, wreg_q, wreg_d;
  logic align_fault_q, align_fault_d, m2r_q, m2r_d, rw_q, rw_d;
  logic accept, mem_op, misal;
`ifdef MEM_ALIGN_CHECK_EN
  assign misal = |ex_alu_result[1:0];
`else
  assign misal = 1'b0;
`endif
  assign accept = ex_valid && state_q == IDLE;
  assign mem_op = ex_mem_read | ex_mem_write;
  always_comb begin
    state_d = state_q;
    dmem_req_d = dmem_req_q;
    dmem_we_d = dmem_we_q;
    dmem_addr_d = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    pc_src_d = 1'b0;
    pc_target_d = pc_target_q;
    wb_valid_d = 1'b0;
    wb_reg_write_d = wb_reg_write_q;
    wb_write_reg_d = wb_write_reg_q;
    wb_data_d = wb_data_q;
    align_fault_d = 1'b0;
    alu_d = alu_q;
    m2r_d = m2r_q;
    rw_d = rw_q;
    wreg_d = wreg_q;
    if (accept) begin
      alu_d = ex_alu_result;
      m2r_d = ex_mem_to_reg;
      rw_d = ex_reg_write & |ex_write_reg;
      wreg_d = ex_write_reg;
      pc_src_d = ex_branch & ex_zero;
      pc_target_d = ex_branch_target;
      if (mem_op && !misal) begin
        state_d = ACCESS;
        dmem_req_d = 1'b1;
        dmem_we_d = ex_mem_write;
        dmem_addr_d = {ex_alu_result[DATA_W-1:2], 2'b00};
        dmem_wdata_d = ex_write_data;
      end else begin
        wb_valid_d = 1'b1;
        wb_data_d = ex_alu_result;
        wb_write_reg_d = ex_write_reg;
        wb_reg_write_d = ex_reg_write & |ex_write_reg & ~misal;
        align_fault_d = misal;
      end
    end else if (state_q == ACCESS && dmem_ack) begin
      state_d = IDLE;
      dmem_req_d = 1'b0;
      wb_valid_d = 1'b1;
      wb_data_d = m2r_q ? dmem_rdata : alu_q;
      wb_write_reg_d = wreg_q;
      wb_reg_write_d = rw_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dmem_req_q <= 1'b0;
      dmem_we_q <= 1'b0;
      dmem_addr_q <= '0;
      dmem_wdata_q <= '0;
      pc_src_q <= 1'b0;
      pc_target_q <= '0;
      wb_valid_q <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_write_reg_q <= '0;
      wb_data_q <= '0;
      align_fault_q <= 1'b0;
      alu_q <= '0;
      m2r_q <= 1'b0;
      rw_q <= 1'b0;
      wreg_q <= '0;
    end else begin
      state_q <= state_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q <= dmem_we_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      pc_src_q <= pc_src_d;
      pc_target_q <= pc_target_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_write_reg_q <= wb_write_reg_d;
      wb_data_q <= wb_data_d;
      align_fault_q <= align_fault_d;
      alu_q <= alu_d;
      m2r_q <= m2r_d;
      rw_q <= rw_d;
      wreg_q <= wreg_d;
    end
  end
  assign ex_ready = state_q == IDLE;
  assign dmem_req = dmem_req_q;
  assign dmem_we = dmem_we_q;
  assign dmem_addr = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign pc_src = pc_src_q;
  assign pc_branch_target = pc_target_q;
  assign wb_valid = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_write_reg = wb_write_reg_q;
  assign wb_data = wb_data_q;
  assign align_fault = align_fault_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vectors for mem_access_stage, outputs sampled on negedge
module tb_mem_access_stage;
  logic clk = 1'b0, reset = 1'b1;
  logic ex_valid, ex_ready, ex_zero, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [31:0] ex_alu_result, ex_write_data, ex_branch_target;
  logic [4:0] ex_write_reg, wb_write_reg;
  logic dmem_req, dmem_we, dmem_ack, pc_src, wb_valid, wb_reg_write, align_fault;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, pc_branch_target, wb_data;
  int checks = 0, errors = 0;
  mem_access_stage dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_zero(ex_zero), .ex_write_data(ex_write_data),
    .ex_write_reg(ex_write_reg), .ex_branch_target(ex_branch_target), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .pc_src(pc_src), .pc_branch_target(pc_branch_target),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_data(wb_data), .align_fault(align_fault)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    ex_valid = 0; ex_zero = 0; ex_branch = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_reg_write = 0; ex_mem_to_reg = 0; ex_alu_result = 0; ex_write_data = 0;
    ex_write_reg = 0; ex_branch_target = 0;
  endtask
  task automatic issue(input logic br, input logic z, input logic mr, input logic mw,
                       input logic rw, input logic m2r, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] tgt, input logic [4:0] wr);
    ex_valid = 1; ex_branch = br; ex_zero = z; ex_mem_read = mr; ex_mem_write = mw;
    ex_reg_write = rw; ex_mem_to_reg = m2r; ex_alu_result = alu; ex_write_data = wd;
    ex_branch_target = tgt; ex_write_reg = wr;
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
  initial begin
    idle();
    dmem_ack = 0; dmem_rdata = 0;
    repeat (2) step();
    chk("rst_req", dmem_req, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_pcsrc", pc_src, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_fault", align_fault, 0);
    chk("rst_ready", ex_ready, 1);
    reset = 0;
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    chk("stray_ack_wbv", wb_valid, 0);
    chk("stray_ack_ready", ex_ready, 1);
    issue(0, 0, 0, 0, 1, 0, 32'h7, 0, 0, 5'd3);
    step();
    issue(0, 0, 0, 0, 1, 0, 32'h9, 0, 0, 5'd0);
    chk("r_wbv", wb_valid, 1);
    chk("r_data", wb_data, 32'h7);
    chk("r_reg", wb_write_reg, 3);
    chk("r_rw", wb_reg_write, 1);
    chk("r_req", dmem_req, 0);
    chk("r_ready", ex_ready, 1);
    step();
    idle();
    chk("r0_wbv", wb_valid, 1);
    chk("r0_data", wb_data, 32'h9);
    chk("r0_rw", wb_reg_write, 0);
    step();
    chk("r_idle_wbv", wb_valid, 0);
    issue(0, 0, 1, 0, 1, 1, 32'h100, 0, 0, 5'd5);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("ld_req", dmem_req, 1);
      chk("ld_addr", dmem_addr, 32'h100);
      chk("ld_we", dmem_we, 0);
      chk("ld_ready", ex_ready, 0);
      chk("ld_wbv", wb_valid, 0);
      if (i == 2) begin
        dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
      end
      step();
    end
    dmem_ack = 0; dmem_rdata = 0;
    chk("ld_req_done", dmem_req, 0);
    chk("ld_wbv", wb_valid, 1);
    chk("ld_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_reg", wb_write_reg, 5);
    chk("ld_rw", wb_reg_write, 1);
    chk("ld_ready_done", ex_ready, 1);
    step();
    chk("ld_wbv_once", wb_valid, 0);
    issue(0, 0, 0, 1, 0, 0, 32'h104, 32'h1234, 0, 5'd2);
    step();
    idle();
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_addr", dmem_addr, 32'h104);
    chk("st_wdata", dmem_wdata, 32'h1234);
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    chk("st_wbv", wb_valid, 1);
    chk("st_rw", wb_reg_write, 0);
    chk("st_req_done", dmem_req, 0);
    issue(0, 0, 0, 0, 1, 0, 32'h55, 0, 0, 5'd7);
    step();
    idle();
    chk("st_next_wbv", wb_valid, 1);
    chk("st_next_data", wb_data, 32'h55);
    issue(1, 1, 0, 0, 0, 0, 0, 0, 32'h0040_0020, 5'd0);
    step();
    idle();
    chk("br_pcsrc", pc_src, 1);
    chk("br_target", pc_branch_target, 32'h0040_0020);
    step();
    chk("br_pcsrc_once", pc_src, 0);
    issue(1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0020, 5'd0);
    step();
    idle();
    chk("brnt_pcsrc", pc_src, 0);
    chk("brnt_wbv", wb_valid, 1);
    issue(1, 1, 1, 0, 1, 1, 32'h200, 0, 32'h0000_0400, 5'd6);
    step();
    idle();
    chk("brmem_pcsrc", pc_src, 1);
    chk("brmem_target", pc_branch_target, 32'h400);
    chk("brmem_req", dmem_req, 1);
    dmem_ack = 1; dmem_rdata = 32'hCAFE_0001;
    step();
    dmem_ack = 0;
    chk("brmem_pcsrc_off", pc_src, 0);
    chk("brmem_data", wb_data, 32'hCAFE_0001);
    issue(0, 0, 1, 0, 1, 1, 32'h300, 0, 0, 5'd8);
    step();
    idle();
    chk("rs_req1", dmem_req, 1);
    step();
    chk("rs_req2", dmem_req, 1);
    reset = 1;
    step();
    reset = 0;
    dmem_ack = 1; dmem_rdata = 32'h1111_2222;
    chk("rs_req", dmem_req, 0);
    chk("rs_ready", ex_ready, 1);
    chk("rs_wbv", wb_valid, 0);
    step();
    dmem_ack = 0;
    chk("rs_late_wbv", wb_valid, 0);
    chk("rs_late_req", dmem_req, 0);
    issue(0, 0, 1, 0, 1, 1, 32'h102, 0, 0, 5'd4);
    step();
    idle();
`ifdef MEM_ALIGN_CHECK_EN
    chk("al_req", dmem_req, 0);
    chk("al_fault", align_fault, 1);
    chk("al_wbv", wb_valid, 1);
    chk("al_rw", wb_reg_write, 0);
    chk("al_ready", ex_ready, 1);
    step();
    chk("al_fault_once", align_fault, 0);
`else
    chk("al_req", dmem_req, 1);
    chk("al_addr", dmem_addr, 32'h100);
    chk("al_fault", align_fault, 0);
    dmem_ack = 1; dmem_rdata = 32'h0BAD_F00D;
    step();
    dmem_ack = 0;
    chk("al_wbv", wb_valid, 1);
    chk("al_data", wb_data, 32'h0BAD_F00D);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
